// File: rtl/rx_digit_seq.sv
// Operand front-end for the radix-4 interleaved modular multiplier: latches x/y,
// registers the x, 2x and 3x multiples and streams y two bits per cycle, MSB first.
module rx_digit_seq #(
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic [W+1:0] rx1,
  output logic [W+1:0] rx2,
  output logic [W+1:0] rx3,
  output logic [1:0]   sel,
  output logic         digit_valid,
  output logic         digit_last,
  input  logic         digit_ready,
  output logic         done
);

  localparam logic [CW-1:0] LAST_IDX = CW'(W / 2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sreg;
  logic          load, consume, advance;

  function automatic logic [W+1:0] times1(input logic [W-1:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [W+1:0] times2(input logic [W-1:0] v);
    return {1'b0, v, 1'b0};
  endfunction

  // 3x always fits in W+2 bits: 3*(2^W-1) < 2^(W+2)
  function automatic logic [W+1:0] times3(input logic [W-1:0] v);
    return times1(v) + times2(v);
  endfunction

  always_comb begin
    next_state  = state;
    load        = 1'b0;
    consume     = 1'b0;
    advance     = 1'b0;
    busy        = 1'b0;
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    done        = 1'b0;
    sel         = 2'b00;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        digit_valid = 1'b1;
        sel         = sreg[W-1:W-2];
        digit_last  = (cnt == '0);
        consume     = digit_ready;
        if (consume) begin
          if (cnt == '0) next_state = DONE;
          else           advance    = 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sreg <= '0;
      rx1  <= '0;
      rx2  <= '0;
      rx3  <= '0;
    end else if (load) begin
      cnt  <= LAST_IDX;
      sreg <= y;
      rx1  <= times1(x);
      rx2  <= times2(x);
      rx3  <= times3(x);
    end else if (advance) begin
      cnt  <= cnt - 1'b1;
      sreg <= {sreg[W-3:0], 2'b00};
    end
  end

endmodule

// File: tb/tb_rx_digit_seq.sv
// Bench for rx_digit_seq (W=8): expected digits are queued when an operation is
// started and popped as the consumer accepts them.
module tb_rx_digit_seq;

  localparam int W = 8;
  localparam int ND = W / 2;

  logic         clk = 1'b0;
  logic         rst, start, digit_ready;
  logic [W-1:0] x, y;
  logic         busy, digit_valid, digit_last, done;
  logic [W+1:0] rx1, rx2, rx3;
  logic [1:0]   sel;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  rx_digit_seq #(.W(W), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .busy(busy),
    .rx1(rx1), .rx2(rx2), .rx3(rx3), .sel(sel), .digit_valid(digit_valid),
    .digit_last(digit_last), .digit_ready(digit_ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push_digits(input logic [W-1:0] yv);
    for (int i = 0; i < ND; i++)
      exp_q.push_back({yv[W-1-2*i -: 2], (i == ND - 1) ? 1'b1 : 1'b0});
  endtask

  task automatic do_start(input logic [W-1:0] xv, input logic [W-1:0] yv);
    @(negedge clk);
    start = 1'b1; x = xv; y = yv;
    push_digits(yv);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Consumes ND digits; stalls the consumer for stall_len cycles while digit
  // index stall_at is presented. Returns number of cycles used.
  task automatic drain(input int stall_at, input int stall_len, output int cycles);
    int consumed = 0;
    int stalled = 0;
    int n = 0;
    logic rdy;
    while (consumed < ND && n < 60) begin
      @(negedge clk);
      n++;
      rdy = !(consumed == stall_at && stalled < stall_len);
      if (!rdy) stalled++;
      digit_ready = rdy;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL drain_done_early: done=%b required 0", done);
      end
      if (digit_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_digit: sel=%0d with empty queue", sel);
        end else if ({sel, digit_last} !== exp_q[0]) begin
          errors++;
          $display("FAIL digit%0d: sel=%0d last=%b required sel=%0d last=%b",
                   consumed, sel, digit_last, exp_q[0][2:1], exp_q[0][0]);
        end
        if (rdy) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          consumed++;
        end
      end
    end
    digit_ready = 1'b1;
    cycles = n;
    if (consumed < ND) begin
      errors++;
      $display("FAIL drain_timeout: consumed %0d digits required %0d", consumed, ND);
    end
  endtask

  task automatic check_done_pulse(input string tag);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || digit_valid !== 1'b0 || sel !== 2'b00) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b valid=%b sel=%0d required 1 0 0 0",
               tag, done, busy, digit_valid, sel);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width: done=%b required 0", tag, done);
    end
  endtask

  task automatic check_rx(input string tag, input logic [W+1:0] e1, input logic [W+1:0] e2,
                          input logic [W+1:0] e3);
    checks++;
    if (rx1 !== e1 || rx2 !== e2 || rx3 !== e3) begin
      errors++;
      $display("FAIL %s_rx: rx1=%h rx2=%h rx3=%h required %h %h %h",
               tag, rx1, rx2, rx3, e1, e2, e3);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (busy !== 0 || digit_valid !== 0 || digit_last !== 0 || done !== 0 || sel !== 0 ||
        rx1 !== 0 || rx2 !== 0 || rx3 !== 0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b last=%b done=%b sel=%0d rx3=%h required all 0",
               busy, digit_valid, digit_last, done, sel, rx3);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    do_start(8'hB5, 8'h9C);
    check_rx("basic", 10'h0B5, 10'h16A, 10'h21F);
    drain(-1, 0, cyc);
    checks++;
    if (cyc != ND) begin
      errors++;
      $display("FAIL basic_latency: %0d cycles required %0d", cyc, ND);
    end
    check_done_pulse("basic");
  endtask

  task automatic test_stall();
    int cyc;
    do_start(8'hB5, 8'h9C);
    drain(1, 3, cyc);
    checks++;
    if (cyc != ND + 3) begin
      errors++;
      $display("FAIL stall_latency: %0d cycles required %0d", cyc, ND + 3);
    end
    check_done_pulse("stall");
  endtask

  task automatic test_start_held();
    int cyc;
    do_start(8'hB5, 8'h9C);
    start = 1'b1; x = 8'h01; y = 8'hFF;
    drain(-1, 0, cyc);
    check_rx("held_run", 10'h0B5, 10'h16A, 10'h21F);
    check_done_pulse("held");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_idle_busy: busy=%b required 0", busy);
    end
    check_rx("held_idle", 10'h0B5, 10'h16A, 10'h21F);
    push_digits(8'hFF);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_accept: busy=%b required 1", busy);
    end
    check_rx("held_new", 10'h001, 10'h002, 10'h003);
    drain(-1, 0, cyc);
    check_done_pulse("held2");
  endtask

  task automatic test_zero_y();
    int cyc;
    do_start(8'hFF, 8'h00);
    check_rx("zero_y", 10'h0FF, 10'h1FE, 10'h2FD);
    drain(-1, 0, cyc);
    check_done_pulse("zero_y");
  endtask

  task automatic test_async_reset();
    int cyc;
    do_start(8'h5A, 8'hE4);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 0 || digit_valid !== 0 || sel !== 0 || done !== 0 || digit_last !== 0 ||
        rx1 !== 0 || rx2 !== 0 || rx3 !== 0) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b sel=%0d rx1=%h required 0",
               busy, digit_valid, sel, rx1);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b required 0", busy);
    end
    do_start(8'h33, 8'h1B);
    check_rx("post_reset", 10'h033, 10'h066, 10'h099);
    drain(-1, 0, cyc);
    check_done_pulse("post_reset");
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_start(8'hC3, 8'h6D);
    drain(-1, 0, cyc);
    check_done_pulse("b2b_a");
    do_start(8'h7E, 8'hB2);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
    end
    check_rx("b2b", 10'h07E, 10'h0FC, 10'h17A);
    drain(-1, 0, cyc);
    check_done_pulse("b2b_b");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; y = '0; digit_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_start_held();
    test_zero_y();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty: %0d digits left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
